// File: rtl/apb_decoder_mux.sv
// APB fan-out: page decode to a registered one-hot select, slave response muxed back to the master.
// Adds one SETUP cycle, then zero added latency in ACCESS; unmapped and stalled slaves are answered with an error.
module apb_decoder_mux #(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int PAGE_LO  = 8,
    parameter logic [N_SLAVES*(ADDR_W-PAGE_LO)-1:0] BASE_PAGES = {8'h03, 8'h02, 8'h01, 8'h00},
    parameter int TIMEOUT  = 64,
    parameter logic [DATA_W-1:0] DEFAULT_RDATA = 8'hFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            m_paddr,
    input  logic [DATA_W-1:0]            m_pwdata,
    input  logic                         m_pwrite,
    input  logic                         m_psel,
    input  logic                         m_penable,
    output logic [DATA_W-1:0]            m_prdata,
    output logic                         m_pready,
    output logic                         m_pslverr,
    output logic [ADDR_W-1:0]            s_paddr,
    output logic [DATA_W-1:0]            s_pwdata,
    output logic                         s_pwrite,
    output logic                         s_penable,
    output logic [N_SLAVES-1:0]          s_psel,
    input  logic [N_SLAVES*DATA_W-1:0]   s_prdata,
    input  logic [N_SLAVES-1:0]          s_pready,
    input  logic [N_SLAVES-1:0]          s_pslverr,
    output logic                         timeout_pulse,
    output logic [7:0]                   err_count,
    output logic [ADDR_W-1:0]            err_addr
);

    localparam int PW    = ADDR_W - PAGE_LO;
    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t             state, next_state;
    logic [IDX_W-1:0]   sel_idx, dec_idx;
    logic               hit, dec_hit, load_sel;
    logic [WD_W-1:0]    wdog;
    logic [ADDR_W-1:0]  xfer_addr;
    logic [PW-1:0]      page;
    logic               sel_ready, sel_err, wd_expire;
    logic [DATA_W-1:0]  sel_rdata;

    assign s_paddr  = m_paddr;
    assign s_pwdata = m_pwdata;
    assign s_pwrite = m_pwrite;

    assign page = m_paddr[ADDR_W-1:PAGE_LO];

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (page == BASE_PAGES[i*PW +: PW]) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
    end

    assign sel_ready = s_pready[sel_idx];
    assign sel_err   = s_pslverr[sel_idx];
    assign sel_rdata = s_prdata[sel_idx*DATA_W +: DATA_W];
    assign wd_expire = (TIMEOUT != 0) && (wdog == WD_LAST) && !sel_ready;

    always_comb begin
        next_state    = state;
        load_sel      = 1'b0;
        s_psel        = '0;
        s_penable     = 1'b0;
        m_pready      = 1'b0;
        m_pslverr     = 1'b0;
        m_prdata      = '0;
        timeout_pulse = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (m_psel && !m_penable) begin
                    next_state = SETUP;
                    load_sel   = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            SETUP: begin
                if (!m_psel) begin
                    next_state = IDLE;
                end else begin
                    s_psel[sel_idx] = hit;
                    next_state      = ACCESS;
                end
            end
            ACCESS: begin
                // A master dropping psel abandons the transfer without a response.
                if (!m_psel) begin
                    next_state = IDLE;
                end else if (!hit) begin
                    m_pready   = 1'b1;
                    m_pslverr  = 1'b1;
                    m_prdata   = DEFAULT_RDATA;
                    next_state = DONE;
                end else if (wd_expire) begin
                    m_pready      = 1'b1;
                    m_pslverr     = 1'b1;
                    m_prdata      = DEFAULT_RDATA;
                    timeout_pulse = 1'b1;
                    next_state    = DONE;
                end else begin
                    s_psel[sel_idx] = 1'b1;
                    s_penable       = m_penable;
                    m_pready        = sel_ready;
                    m_pslverr       = sel_ready && sel_err;
                    m_prdata        = sel_rdata;
                    if (sel_ready) next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel_idx   <= '0;
            hit       <= 1'b0;
            wdog      <= '0;
            xfer_addr <= '0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            state <= next_state;
            if (load_sel) begin
                sel_idx   <= dec_idx;
                hit       <= dec_hit;
                xfer_addr <= m_paddr;
            end
            if (state == ACCESS) wdog <= wdog + 1'b1;
            else                 wdog <= '0;
            if (m_pready && m_pslverr) begin
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                err_addr <= xfer_addr;
            end
        end
    end

endmodule

// File: tb/tb_apb_decoder_mux.sv
// Directed bench for apb_decoder_mux: drives inputs on the falling edge, checks 1 time unit later.
module tb_apb_decoder_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] m_paddr;
    logic [7:0]  m_pwdata;
    logic        m_pwrite, m_psel, m_penable;
    logic [7:0]  m_prdata;
    logic        m_pready, m_pslverr;
    logic [15:0] s_paddr;
    logic [7:0]  s_pwdata;
    logic        s_pwrite, s_penable;
    logic [3:0]  s_psel;
    logic [31:0] s_prdata;
    logic [3:0]  s_pready, s_pslverr;
    logic        timeout_pulse;
    logic [7:0]  err_count;
    logic [15:0] err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apb_decoder_mux dut (
        .clk(clk), .rst(rst),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite),
        .m_psel(m_psel), .m_penable(m_penable),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(s_pwrite),
        .s_penable(s_penable), .s_psel(s_psel),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .timeout_pulse(timeout_pulse), .err_count(err_count), .err_addr(err_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic unmapped_read();
        @(negedge clk); m_psel = 1'b1; m_penable = 1'b0; m_paddr = 16'h0A00;
        @(negedge clk); m_penable = 1'b1;
        @(negedge clk);
        @(negedge clk); m_psel = 1'b0; m_penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1;
        m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
        s_prdata = '0; s_pready = '0; s_pslverr = '0;
        #1;
        chk("rst_psel", s_psel, 4'b0000);
        chk("rst_penable", s_penable, 1'b0);
        chk("rst_pready", m_pready, 1'b0);
        chk("rst_pslverr", m_pslverr, 1'b0);
        chk("rst_prdata", m_prdata, 8'h00);
        chk("rst_err_count", err_count, 8'h00);
        chk("rst_err_addr", err_addr, 16'h0000);
        chk("rst_tpulse", timeout_pulse, 1'b0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Read 0x0103 from slave1, two wait states, address changes mid-access
        @(negedge clk); m_psel = 1'b1; m_penable = 1'b0; m_paddr = 16'h0103; m_pwrite = 1'b0; #1;
        chk("t1_idle_psel", s_psel, 4'b0000);
        chk("t1_paddr_pass", s_paddr, 16'h0103);
        @(negedge clk); m_penable = 1'b1; #1;
        chk("t1_setup_psel", s_psel, 4'b0010);
        chk("t1_setup_penable", s_penable, 1'b0);
        chk("t1_setup_pready", m_pready, 1'b0);
        @(negedge clk); m_paddr = 16'h0300; #1;
        chk("t1_acc1_psel", s_psel, 4'b0010);
        chk("t1_acc1_penable", s_penable, 1'b1);
        chk("t1_acc1_pready", m_pready, 1'b0);
        @(negedge clk); #1;
        chk("t1_acc2_psel", s_psel, 4'b0010);
        chk("t1_acc2_pready", m_pready, 1'b0);
        @(negedge clk); s_pready = 4'b0010; s_prdata = 32'h0000_5A00; #1;
        chk("t1_acc3_psel", s_psel, 4'b0010);
        chk("t1_acc3_pready", m_pready, 1'b1);
        chk("t1_acc3_prdata", m_prdata, 8'h5A);
        chk("t1_acc3_pslverr", m_pslverr, 1'b0);
        @(negedge clk); m_psel = 1'b0; m_penable = 1'b0; s_pready = '0; #1;
        chk("t1_done_psel", s_psel, 4'b0000);
        chk("t1_done_pready", m_pready, 1'b0);
        chk("t1_err_count", err_count, 8'd0);

        // Write 0x77 to 0x0200, slave2 ready at once
        @(negedge clk); m_psel = 1'b1; m_paddr = 16'h0200; m_pwrite = 1'b1; m_pwdata = 8'h77; #1;
        chk("t2_pwdata_pass", s_pwdata, 8'h77);
        chk("t2_pwrite_pass", s_pwrite, 1'b1);
        @(negedge clk); m_penable = 1'b1; s_pready = 4'b0100; #1;
        chk("t2_setup_psel", s_psel, 4'b0100);
        chk("t2_setup_pready", m_pready, 1'b0);
        @(negedge clk); #1;
        chk("t2_acc_psel", s_psel, 4'b0100);
        chk("t2_acc_pready", m_pready, 1'b1);
        chk("t2_acc_pslverr", m_pslverr, 1'b0);

        // Back-to-back unmapped read at 0x0900 issued in the DONE cycle
        @(negedge clk); m_penable = 1'b0; m_paddr = 16'h0900; m_pwrite = 1'b0; s_pready = '0; #1;
        chk("t3_done_psel", s_psel, 4'b0000);
        chk("t3_done_pready", m_pready, 1'b0);
        @(negedge clk); m_penable = 1'b1; #1;
        chk("t3_setup_psel", s_psel, 4'b0000);
        @(negedge clk); #1;
        chk("t3_acc_psel", s_psel, 4'b0000);
        chk("t3_acc_pready", m_pready, 1'b1);
        chk("t3_acc_pslverr", m_pslverr, 1'b1);
        chk("t3_acc_prdata", m_prdata, 8'hFF);
        @(negedge clk); m_psel = 1'b0; m_penable = 1'b0; #1;
        chk("t3_err_count", err_count, 8'd1);
        chk("t3_err_addr", err_addr, 16'h0900);

        // Slave3 never ready: abort on the 64th access cycle
        @(negedge clk); m_psel = 1'b1; m_paddr = 16'h0310;
        @(negedge clk); m_penable = 1'b1; #1;
        chk("t4_setup_psel", s_psel, 4'b1000);
        for (int k = 1; k <= 63; k++) begin
            @(negedge clk);
            if (k == 2) m_paddr = 16'h0000;
            #1;
            chk("t4_wait_psel", s_psel, 4'b1000);
            chk("t4_wait_tpulse", timeout_pulse, 1'b0);
            chk("t4_wait_pready", m_pready, 1'b0);
        end
        chk("t4_paddr_pass", s_paddr, 16'h0000);
        @(negedge clk); #1;
        chk("t4_abort_tpulse", timeout_pulse, 1'b1);
        chk("t4_abort_pready", m_pready, 1'b1);
        chk("t4_abort_pslverr", m_pslverr, 1'b1);
        chk("t4_abort_prdata", m_prdata, 8'hFF);
        chk("t4_abort_psel", s_psel, 4'b0000);
        chk("t4_abort_penable", s_penable, 1'b0);
        @(negedge clk); m_psel = 1'b0; m_penable = 1'b0; #1;
        chk("t4_done_tpulse", timeout_pulse, 1'b0);
        chk("t4_err_count", err_count, 8'd2);
        chk("t4_err_addr", err_addr, 16'h0310);

        // Slave0 reports an error
        @(negedge clk); m_psel = 1'b1; m_paddr = 16'h0005;
        @(negedge clk); m_penable = 1'b1; s_pready = 4'b0001; s_pslverr = 4'b0001; s_prdata = 32'h0000_0011;
        @(negedge clk); #1;
        chk("t5_acc_pslverr", m_pslverr, 1'b1);
        chk("t5_acc_prdata", m_prdata, 8'h11);
        @(negedge clk); m_psel = 1'b0; m_penable = 1'b0; s_pready = '0; s_pslverr = '0; #1;
        chk("t5_err_count", err_count, 8'd3);
        chk("t5_err_addr", err_addr, 16'h0005);

        // Master drops psel mid-access
        @(negedge clk); m_psel = 1'b1; m_paddr = 16'h0100;
        @(negedge clk); m_penable = 1'b1;
        @(negedge clk); #1;
        chk("t6_acc_psel", s_psel, 4'b0010);
        @(negedge clk); m_psel = 1'b0; m_penable = 1'b0; #1;
        chk("t6_drop_psel", s_psel, 4'b0000);
        chk("t6_drop_penable", s_penable, 1'b0);
        chk("t6_drop_pready", m_pready, 1'b0);
        @(negedge clk); #1;
        chk("t6_err_count", err_count, 8'd3);

        // Saturation: 300 unmapped reads in total
        for (int n = 0; n < 251; n++) unmapped_read();
        #1; chk("t7_err_254", err_count, 8'd254);
        unmapped_read();
        #1; chk("t7_err_255", err_count, 8'd255);
        for (int n = 0; n < 48; n++) unmapped_read();
        #1; chk("t7_err_sat", err_count, 8'd255);

        // Asynchronous reset in the middle of an access to slave0
        @(negedge clk); m_psel = 1'b1; m_paddr = 16'h0000; s_prdata = 32'h0000_003C;
        @(negedge clk); m_penable = 1'b1;
        @(negedge clk); #1;
        chk("t8_acc_psel", s_psel, 4'b0001);
        chk("t8_acc_prdata", m_prdata, 8'h3C);
        #1; rst = 1'b1; #1;
        chk("t8_rst_psel", s_psel, 4'b0000);
        chk("t8_rst_penable", s_penable, 1'b0);
        chk("t8_rst_prdata", m_prdata, 8'h00);
        chk("t8_rst_pready", m_pready, 1'b0);
        chk("t8_rst_err_count", err_count, 8'd0);
        chk("t8_rst_err_addr", err_addr, 16'h0000);
        @(negedge clk); rst = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
        @(negedge clk); m_psel = 1'b1;
        @(negedge clk); m_penable = 1'b1; s_pready = 4'b0001; #1;
        chk("t8_setup_psel", s_psel, 4'b0001);
        @(negedge clk); #1;
        chk("t8_acc_pready", m_pready, 1'b1);
        chk("t8_acc_prdata2", m_prdata, 8'h3C);
        chk("t8_acc_pslverr", m_pslverr, 1'b0);
        @(negedge clk); m_psel = 1'b0; m_penable = 1'b0; s_pready = '0; #1;
        chk("t8_err_count", err_count, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_decoder_mux.md
Name: apb_decoder_mux

Overview:
Parametrised APB fan-out for the system I/O bus, replacing hand-written per-peripheral psel decode and prdata/pready muxing at the FPGA top level. It sits between the single APB master port from the system block and N_SLAVES peripherals such as UARTs and GPIOs. It adds features the hand-written decode lacks:
- a registered slave select, held for the whole transfer;
- an error response for unmapped pages;
- a watchdog timeout for stalled slaves;
- error status registers.

Parameters:
N_SLAVES, 4, number of slave ports (1..16)
ADDR_W, 16, APB address width
DATA_W, 8, APB data width
PAGE_LO, 8, lowest paddr bit used for decode; page = paddr[ADDR_W-1:PAGE_LO]
BASE_PAGES, {8'h03,8'h02,8'h01,8'h00}, packed vector of ADDR_W-PAGE_LO bits per slave; slave i matches page == BASE_PAGES[i]
TIMEOUT, 64, max access-phase cycles before abort; 0 disables the watchdog
DEFAULT_RDATA, 8'hFF, prdata value returned on error/abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
m_paddr  in  ADDR_W  master address
m_pwdata  in  DATA_W  master write data
m_pwrite  in  1  master write strobe
m_psel  in  1  master select
m_penable  in  1  master enable
m_prdata  out  DATA_W  read data to master
m_pready  out  1  ready to master
m_pslverr  out  1  error to master
s_paddr  out  ADDR_W  broadcast address (= m_paddr)
s_pwdata  out  DATA_W  broadcast write data
s_pwrite  out  1  broadcast write
s_penable  out  1  broadcast enable (m_penable gated by state ACCESS)
s_psel  out  N_SLAVES  one-hot slave select
s_prdata  in  N_SLAVES*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
s_pready  in  N_SLAVES  slave ready
s_pslverr  in  N_SLAVES  slave error
timeout_pulse  out  1  one-cycle pulse on watchdog abort
err_count  out  8  saturating count of error responses (unmapped, slave error, timeout)
err_addr  out  ADDR_W  m_paddr of the most recent errored transfer

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous, active-high.
- Reset values: state=IDLE, sel_idx=0, hit=0, wdog=0, err_count=0, err_addr=0, timeout_pulse=0.
  - While in reset: s_psel=0, s_penable=0, m_pready=0, m_pslverr=0, m_prdata=0.
- Decode:
  - Combinational on m_paddr during SETUP.
  - Lowest matching index wins on overlapping BASE_PAGES.
  - No match: unmapped.
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - IDLE: m_psel & !m_penable -> SETUP. Decoded index and hit flag are registered on this edge.
  - SETUP (1 cycle):
    - s_psel[sel_idx] driven only if hit; s_penable=0.
    - Next state is ACCESS.
  - ACCESS:
    - s_psel held from the registered index; s_penable=m_penable; wdog increments each cycle.
    - Mapped: m_pready, m_pslverr and m_prdata follow the selected slave combinationally (zero added latency).
    - Unmapped: m_pready=1, m_pslverr=1, m_prdata=DEFAULT_RDATA on the first ACCESS cycle; no slave selected.
    - Completion (m_pready=1): -> DONE.
    - Watchdog: when TIMEOUT!=0 and wdog==TIMEOUT-1 without s_pready, force m_pready=1, m_pslverr=1, m_prdata=DEFAULT_RDATA, drop s_psel/s_penable, pulse timeout_pulse, -> DONE.
  - DONE (1 cycle): wdog=0. If m_psel & !m_penable this cycle, behave as IDLE (back-to-back setup); else -> IDLE.
- Master protocol violation: m_psel falling in SETUP/ACCESS -> IDLE immediately, slave select dropped, no error counted.
- Error status (err_count, err_addr):
  - On any completion with m_pslverr=1: err_count += 1, saturating at 255; err_addr <= registered transfer address.
- Outside ACCESS: m_pready=0, m_pslverr=0, m_prdata=0.
- Broadcast signals (s_paddr, s_pwdata, s_pwrite) are pure passthrough in all states.
- Address held from SETUP: slave selection ignores m_paddr changes after SETUP.

Test Plan:
- Read at 0x0103, slave1 pready after 2 wait cycles, prdata 0x5A -> s_psel=4'b0010 for SETUP+3 ACCESS cycles; m_prdata=0x5A, m_pslverr=0, err_count=0.
- Write 0x77 to 0x0200, slave2 ready immediately -> s_psel[2]=1, s_pwdata=0x77, transfer completes in 2 cycles, other s_psel bits 0.
- Read at 0x0900 (unmapped) -> no s_psel; first ACCESS cycle returns m_pready=1, m_pslverr=1, m_prdata=0xFF; err_count=1, err_addr=0x0900.
- Slave3 holds pready=0, TIMEOUT=64 -> abort on the 64th ACCESS cycle; timeout_pulse high for exactly 1 cycle, m_pslverr=1, s_psel drops the same cycle.
- 300 unmapped reads -> err_count saturates at 255.
- rst asserted mid-ACCESS -> all outputs 0 asynchronously. Next transfer after release (0x0000) completes normally on slave0.
